bram_pixel_fetch: RTL

Read-side master for the frame BRAM in the connected-domain filter. On a start command it fetches a run of consecutive 32-bit words over the trig/done BRAM read handshake. It unpacks each word into pixels and presents them as a valid/ready stream to the filter core. It sits directly between the BRAM read port and the filter's pixel input.

---
 rtl/bram_pixel_fetch_if.sv | 23 ++
 rtl/bram_pixel_fetch.sv | 110 +++++++++++
 2 files changed

// File: rtl/bram_pixel_fetch_if.sv
// bram_pixel_fetch_if: BRAM read handshake plus pixel valid/ready stream.
interface bram_pixel_fetch_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_trig;
  logic              bram_done;
  logic [DATA_W-1:0] bram_data;
  logic [PIX_W-1:0]  pix;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;
  modport master (
    output bram_addr, bram_trig, pix, pix_valid, pix_last,
    input  bram_done, bram_data, pix_ready
  );
  modport slave (
    input  bram_addr, bram_trig, pix, pix_valid, pix_last,
    output bram_done, bram_data, pix_ready
  );
endinterface

// File: rtl/bram_pixel_fetch.sv
// bram_pixel_fetch: fetches a run of BRAM words and streams them out as pixels, LSB first.
// Define BRAM_TIMEOUT_EN to abort a read that sees no done within TIMEOUT cycles and flag o_err.
module bram_pixel_fetch #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int PIX_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_num_words,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  bram_pixel_fetch_if.master bus
);
  localparam int PPW   = DATA_W / PIX_W;
  localparam int IDX_W = PPW > 1 ? $clog2(PPW) : 1;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] addr;
  logic              trig;
  logic [DATA_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W:0]   rem;
  logic              done_q;
  logic              xfer, last_pix, tmo, pix_valid;
  assign last_pix      = idx == IDX_W'(PPW - 1);
  assign xfer          = pix_valid && bus.pix_ready;
  assign bus.bram_addr = addr;
  assign bus.bram_trig = trig;
  assign bus.pix       = word[idx*PIX_W +: PIX_W];
  assign bus.pix_valid = pix_valid;
  assign bus.pix_last  = pix_valid && rem == '0 && last_pix;
  assign o_done        = done_q;
`ifdef BRAM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err;
  assign tmo   = state == REQ && !bus.bram_done && wait_cnt == CNT_W'(TIMEOUT - 1);
  assign o_err = err;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= (state == REQ && !bus.bram_done) ? wait_cnt + CNT_W'(1) : '0;
      if (tmo) err <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign o_err = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= nxt;
  end
  always_comb begin
    nxt       = state;
    pix_valid = state == DRAIN;
    o_busy    = state != IDLE;
    if (state == IDLE && i_start && i_num_words != '0) nxt = REQ;
    if (state == REQ) nxt = bus.bram_done ? DRAIN : (tmo ? IDLE : REQ);
    if (state == DRAIN && xfer && last_pix) nxt = rem != '0 ? REQ : IDLE;
  end
  // rem counts the words still to fetch after the one being drained
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr   <= '0;
      trig   <= 1'b0;
      word   <= '0;
      idx    <= '0;
      rem    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && i_start) begin
        if (i_num_words == '0) begin
          done_q <= 1'b1;
        end else begin
          addr <= i_base_addr;
          rem  <= i_num_words - (ADDR_W+1)'(1);
          trig <= 1'b1;
        end
      end else if (state == REQ) begin
        if (bus.bram_done) begin
          word <= bus.bram_data;
          trig <= 1'b0;
          idx  <= '0;
        end else if (tmo) begin
          trig   <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (xfer) begin
        if (!last_pix) begin
          idx <= idx + IDX_W'(1);
        end else if (rem != '0) begin
          addr <= addr + ADDR_W'(1);
          rem  <= rem - (ADDR_W+1)'(1);
          trig <= 1'b1;
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end
endmodule
